// File: rtl/spi_flash_arbiter.sv
// Two-port read arbiter in front of the single-word SPI flash controller.
// Fixed-priority or round-robin grant, word-aligned addressing, one-entry last-word buffer.
module spi_flash_arbiter #(
   parameter int ARB_MODE   = 0,
   parameter bit HIT_BUF_EN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_i,
   input  logic [23:0] req0_addr_i,
   output logic        ack0_o,
   input  logic        req1_i,
   input  logic [23:0] req1_addr_i,
   output logic        ack1_o,
   output logic [31:0] rdata_o,
   input  logic        buf_flush_i,
   output logic [23:0] flash_addr_o,
   output logic        flash_strobe_o,
   input  logic [31:0] flash_data_i,
   input  logic        flash_done_i,
   input  logic        flash_init_i
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   typedef struct packed {
      logic        port;
      logic [21:0] tag;
   } grant_t;

   state_t      state;
   grant_t      cur;
   logic        last_gnt;
   logic        buf_valid;
   logic        flush_seen;
   logic [21:0] buf_tag;
   logic [31:0] buf_data;

   logic        any_req;
   logic        win;
   logic [21:0] win_tag;
   logic        hit;

   // Byte-offset bits never reach the flash; the buffer works on whole words.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{req0_addr_i[1:0], req1_addr_i[1:0]};

   always_comb begin
      any_req = req0_i | req1_i;
      if (req0_i && req1_i)
         win = (ARB_MODE == 0) ? 1'b0 : ~last_gnt;
      else
         win = ~req0_i;
      win_tag = win ? req1_addr_i[23:2] : req0_addr_i[23:2];
      hit     = HIT_BUF_EN && buf_valid && (buf_tag == win_tag) && !buf_flush_i;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         cur            <= '0;
         last_gnt       <= 1'b1;
         buf_valid      <= 1'b0;
         buf_tag        <= '0;
         buf_data       <= '0;
         flush_seen     <= 1'b0;
         ack0_o         <= 1'b0;
         ack1_o         <= 1'b0;
         rdata_o        <= '0;
         flash_addr_o   <= '0;
         flash_strobe_o <= 1'b0;
      end else begin
         ack0_o         <= 1'b0;
         ack1_o         <= 1'b0;
         flash_strobe_o <= 1'b0;
         if (buf_flush_i) begin
            buf_valid  <= 1'b0;
            flush_seen <= 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (flash_init_i && any_req) begin
                  cur      <= '{port: win, tag: win_tag};
                  last_gnt <= win;
                  if (hit) begin
                     rdata_o <= buf_data;
                     ack0_o  <= ~win;
                     ack1_o  <= win;
                     state   <= S_RESP;
                  end else begin
                     flash_strobe_o <= 1'b1;
                     flash_addr_o   <= {win_tag, 2'b00};
                     flush_seen     <= 1'b0;
                     state          <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: state <= S_WAIT;
            S_WAIT: begin
               if (flash_done_i) begin
                  rdata_o <= flash_data_i;
                  // A flush while the word was in flight makes it stale for the buffer.
                  if (!flush_seen && !buf_flush_i) begin
                     buf_valid <= HIT_BUF_EN;
                     buf_tag   <= cur.tag;
                     buf_data  <= flash_data_i;
                  end
                  ack0_o <= ~cur.port;
                  ack1_o <= cur.port;
                  state  <= S_RESP;
               end
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Bench for spi_flash_arbiter: DUT 0 is fixed priority with buffer, DUT 1 round-robin without.
// Each DUT has its own behavioural flash responder returning a per-address word.
module tb_spi_flash_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req0, req1, ack0, ack1, flash_strobe, flash_done, flash_init, flush, prot_err;
   logic [23:0] req0_addr [2];
   logic [23:0] req1_addr [2];
   logic [23:0] flash_addr [2];
   logic [31:0] rdata [2];
   logic [31:0] flash_data [2];

   int flash_lat;
   int n_cmp = 0;
   int n_bad = 0;

   int          grants[$];
   logic [31:0] datas[$];
   int          cycles[$];
   logic [23:0] strobe_q[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [23:0] a);
      logic [23:0] al;
      al = {a[23:2], 2'b00};
      return (al == 24'h10) ? 32'hDEADBEEF : {al[23:2], 10'h2A5};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic        done_r, busy;
      logic        perr = 1'b0;
      logic [31:0] data_r;
      logic [23:0] fa;
      int          cnt;

      spi_flash_arbiter #(.ARB_MODE(g), .HIT_BUF_EN(g == 0)) u_dut (
         .clk(clk), .reset(reset),
         .req0_i(req0[g]), .req0_addr_i(req0_addr[g]), .ack0_o(ack0[g]),
         .req1_i(req1[g]), .req1_addr_i(req1_addr[g]), .ack1_o(ack1[g]),
         .rdata_o(rdata[g]), .buf_flush_i(flush[g]),
         .flash_addr_o(flash_addr[g]), .flash_strobe_o(flash_strobe[g]),
         .flash_data_i(flash_data[g]), .flash_done_i(flash_done[g]),
         .flash_init_i(flash_init[g])
      );

      always @(posedge clk or posedge reset) begin
         if (reset) begin
            busy <= 1'b0; done_r <= 1'b0; data_r <= '0; fa <= '0; cnt <= 0;
         end else begin
            done_r <= 1'b0;
            if (flash_strobe[g] && !busy) begin
               busy <= 1'b1; fa <= flash_addr[g]; cnt <= flash_lat;
            end else if (busy) begin
               if (cnt == 0) begin
                  done_r <= 1'b1; data_r <= word_of(fa); busy <= 1'b0;
               end else cnt <= cnt - 1;
            end
         end
      end

      // Sticky: strobe while the flash is busy or uninitialised.
      always @(posedge clk)
         if (!reset && flash_strobe[g] && (busy || !flash_init[g])) perr <= 1'b1;

      assign flash_done[g] = done_r;
      assign flash_data[g] = data_r;
      assign prot_err[g]   = perr;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, got, exp);
      end
   endtask

   // Drive requests (n0/n1 back-to-back reads per port) and log acks, data and strobes.
   task automatic run(input int d, input int n0, input logic [23:0] a0, input int n1,
                      input logic [23:0] a1, input bit fl, input bit pre_wait);
      int c0, c1, cyc;
      c0 = n0; c1 = n1; cyc = 0;
      grants.delete(); datas.delete(); cycles.delete(); strobe_q.delete();
      if (pre_wait) @(negedge clk);
      req0_addr[d] = a0; req1_addr[d] = a1;
      req0[d] = (c0 > 0); req1[d] = (c1 > 0); flush[d] = fl;
      while ((c0 > 0 || c1 > 0) && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) flush[d] = 1'b0;
         if (flash_strobe[d]) strobe_q.push_back(flash_addr[d]);
         if (ack0[d]) begin
            grants.push_back(0); datas.push_back(rdata[d]); cycles.push_back(cyc);
            if (c0 > 0) c0--;
            if (c0 == 0) req0[d] = 1'b0;
         end
         if (ack1[d]) begin
            grants.push_back(1); datas.push_back(rdata[d]); cycles.push_back(cyc);
            if (c1 > 0) c1--;
            if (c1 == 0) req1[d] = 1'b0;
         end
      end
      check("run_complete", 32'(c0 + c1), 0);
   endtask

   task automatic pulse_flush(input int d);
      @(negedge clk) flush[d] = 1'b1;
      @(negedge clk) flush[d] = 1'b0;
   endtask

   typedef struct {
      int          d;
      int          n0;
      logic [23:0] a0;
      int          n1;
      logic [23:0] a1;
      bit          fl;
      int          first;
      int          nstb;
      logic [31:0] data;
      int          cyc;
   } vec_t;

   vec_t vt [9];

   initial begin
      int          cnt_s, cnt_a, seen;
      bit          mv;
      logic [21:0] mtag;

      vt[0] = '{0, 0, 24'h0,   1, 24'h13,  1'b0, 1, 0, 32'hDEADBEEF,    1};
      vt[1] = '{0, 1, 24'h100, 1, 24'h200, 1'b0, 0, 2, word_of(24'h100), -1};
      vt[2] = '{0, 0, 24'h0,   1, 24'h202, 1'b0, 1, 0, word_of(24'h200), 1};
      vt[3] = '{0, 1, 24'h100, 0, 24'h0,   1'b0, 0, 1, word_of(24'h100), 6};
      vt[4] = '{0, 1, 24'h103, 0, 24'h0,   1'b1, 0, 1, word_of(24'h100), 6};
      vt[5] = '{0, 1, 24'h101, 0, 24'h0,   1'b0, 0, 0, word_of(24'h100), 1};
      vt[6] = '{1, 0, 24'h0,   1, 24'h13,  1'b0, 1, 1, 32'hDEADBEEF,    6};
      vt[7] = '{1, 0, 24'h0,   1, 24'h10,  1'b0, 1, 1, 32'hDEADBEEF,    6};
      vt[8] = '{1, 1, 24'h100, 1, 24'h200, 1'b0, 0, 2, word_of(24'h100), -1};

      reset = 1'b1; req0 = '0; req1 = '0; flush = '0; flash_init = 2'b10; flash_lat = 2;
      for (int d = 0; d < 2; d++) begin req0_addr[d] = '0; req1_addr[d] = '0; end

      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst_ack0_d%0d", d), 32'(ack0[d]), 0);
         check($sformatf("rst_ack1_d%0d", d), 32'(ack1[d]), 0);
         check($sformatf("rst_strobe_d%0d", d), 32'(flash_strobe[d]), 0);
         check($sformatf("rst_rdata_d%0d", d), rdata[d], 0);
         check($sformatf("rst_faddr_d%0d", d), 32'(flash_addr[d]), 0);
      end
      reset = 1'b0;

      // No grant while the flash reports uninitialised.
      @(negedge clk) begin req0[0] = 1'b1; req0_addr[0] = 24'h10; end
      cnt_s = 0; cnt_a = 0;
      repeat (20) begin
         @(negedge clk);
         cnt_s += int'(flash_strobe[0]);
         cnt_a += int'(ack0[0]) + int'(ack1[0]);
      end
      check("gate_strobe", 32'(cnt_s), 0);
      check("gate_ack", 32'(cnt_a), 0);
      flash_init[0] = 1'b1;
      run(0, 1, 24'h10, 0, 24'h0, 1'b0, 1'b0);
      check("gate_nstb", 32'(strobe_q.size()), 1);
      if (strobe_q.size() > 0) check("gate_faddr", 32'(strobe_q[0]), 32'h10);
      if (grants.size() > 0) begin
         check("gate_port", 32'(grants[0]), 0);
         check("gate_data", datas[0], 32'hDEADBEEF);
      end

      for (int i = 0; i < 9; i++) begin
         run(vt[i].d, vt[i].n0, vt[i].a0, vt[i].n1, vt[i].a1, vt[i].fl, 1'b1);
         check($sformatf("v%0d_nack", i), 32'(grants.size()), 32'(vt[i].n0 + vt[i].n1));
         check($sformatf("v%0d_nstb", i), 32'(strobe_q.size()), 32'(vt[i].nstb));
         if (grants.size() > 0) begin
            check($sformatf("v%0d_first", i), 32'(grants[0]), 32'(vt[i].first));
            check($sformatf("v%0d_data", i), datas[0], vt[i].data);
            if (vt[i].cyc >= 0) check($sformatf("v%0d_lat", i), 32'(cycles[0]), 32'(vt[i].cyc));
         end
         if (grants.size() > 1)
            check($sformatf("v%0d_data2", i), datas[1], word_of(grants[1] == 1 ? vt[i].a1 : vt[i].a0));
      end

      // Round-robin with both ports requesting continuously.
      run(1, 4, 24'h100, 4, 24'h200, 1'b0, 1'b1);
      check("rr_nack", 32'(grants.size()), 8);
      if (grants.size() > 0) check("rr_first", 32'(grants[0]), 0);
      for (int k = 1; k < grants.size(); k++)
         check($sformatf("rr_alt%0d", k), 32'(grants[k] != grants[k-1]), 1);

      // Flush while the word is in flight: still returned, but not buffered.
      flash_lat = 6;
      fork
         run(0, 1, 24'h40, 0, 24'h0, 1'b0, 1'b1);
         begin
            @(negedge clk);
            repeat (3) @(negedge clk);
            flush[0] = 1'b1;
            @(negedge clk) flush[0] = 1'b0;
         end
      join
      check("fw_nstb", 32'(strobe_q.size()), 1);
      if (grants.size() > 0) check("fw_data", datas[0], word_of(24'h40));
      run(0, 1, 24'h40, 0, 24'h0, 1'b0, 1'b1);
      check("fw_repeat_nstb", 32'(strobe_q.size()), 1);

      // Reset in the middle of a miss.
      flash_lat = 8;
      @(negedge clk) begin req0[0] = 1'b1; req0_addr[0] = 24'h80; end
      seen = 0;
      for (int k = 0; k < 10 && seen == 0; k++) begin
         @(negedge clk);
         if (flash_strobe[0]) seen = 1;
      end
      check("rw_strobe_seen", 32'(seen), 1);
      @(negedge clk) begin reset = 1'b1; flash_init[0] = 1'b0; req0[0] = 1'b0; end
      #1;
      check("rw_ack0", 32'(ack0[0]), 0);
      check("rw_ack1", 32'(ack1[0]), 0);
      check("rw_strobe", 32'(flash_strobe[0]), 0);
      check("rw_rdata", rdata[0], 0);
      check("rw_faddr", 32'(flash_addr[0]), 0);
      cnt_a = 0;
      repeat (3) @(negedge clk) cnt_a += int'(ack0[0]) + int'(ack1[0]);
      reset = 1'b0;
      repeat (12) @(negedge clk) cnt_a += int'(ack0[0]) + int'(ack1[0]);
      check("rw_no_ack", 32'(cnt_a), 0);
      flash_init[0] = 1'b1;
      run(0, 1, 24'h40, 0, 24'h0, 1'b0, 1'b1);
      check("rw_after_nstb", 32'(strobe_q.size()), 1);
      if (grants.size() > 0) check("rw_after_data", datas[0], word_of(24'h40));

      // Random traffic on DUT 0 against a word-level buffer model.
      pulse_flush(0);
      mv = 1'b0; mtag = '0;
      for (int it = 0; it < 150; it++) begin
         int          kind;
         bit          hit0;
         logic [23:0] ra0, ra1;
         int          ep[$];
         logic [23:0] ea[$];
         logic [23:0] es[$];
         flash_lat = $urandom_range(0, 4);
         if ($urandom_range(0, 5) == 0) begin pulse_flush(0); mv = 1'b0; end
         kind = $urandom_range(0, 2);
         ra0 = 24'h300 + 24'($urandom_range(0, 31));
         ra1 = 24'h300 + 24'($urandom_range(0, 31));
         ep.delete(); ea.delete(); es.delete();
         if (kind != 1) begin ep.push_back(0); ea.push_back(ra0); end
         if (kind != 0) begin ep.push_back(1); ea.push_back(ra1); end
         hit0 = 1'b0;
         foreach (ea[k]) begin
            if (mv && mtag == ea[k][23:2]) begin
               if (k == 0) hit0 = 1'b1;
            end else begin
               es.push_back({ea[k][23:2], 2'b00});
               mv = 1'b1; mtag = ea[k][23:2];
            end
         end
         run(0, kind != 1 ? 1 : 0, ra0, kind != 0 ? 1 : 0, ra1, 1'b0, 1'b1);
         check($sformatf("r%0d_nack", it), 32'(grants.size()), 32'(ep.size()));
         check($sformatf("r%0d_nstb", it), 32'(strobe_q.size()), 32'(es.size()));
         for (int k = 0; k < grants.size() && k < ep.size(); k++) begin
            check($sformatf("r%0d_port%0d", it, k), 32'(grants[k]), 32'(ep[k]));
            check($sformatf("r%0d_data%0d", it, k), datas[k], word_of(ea[k]));
         end
         for (int k = 0; k < strobe_q.size() && k < es.size(); k++)
            check($sformatf("r%0d_faddr%0d", it, k), 32'(strobe_q[k]), 32'(es[k]));
         if (kind != 2 && grants.size() > 0)
            check($sformatf("r%0d_lat", it), 32'(cycles[0]), hit0 ? 32'd1 : 32'(4 + flash_lat));
      end

      check("prot_d0", 32'(prot_err[0]), 0);
      check("prot_d1", 32'(prot_err[1]), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
